// File: rtl/irq_gateway_pkg.sv
// Shared defaults and per-source state encoding for the interrupt gateway.
package irq_gateway_pkg;

  localparam int IRQ_N_SRC_DEF       = 6;
  localparam int IRQ_SYNC_STAGES_DEF = 2;
  localparam int IRQ_ID_W            = 3;

  typedef enum logic {
    IRQ_IDLE    = 1'b0,
    IRQ_PENDING = 1'b1
  } irq_state_e;

  // A single flop cannot resolve metastability, so depth is clamped to two.
  function automatic int irq_sync_depth(int stages);
    return (stages < 2) ? 2 : stages;
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Single-bit flop-chain synchronizer for an asynchronous interrupt line.
module irq_sync
  import irq_gateway_pkg::*;
#(
  parameter int STAGES = IRQ_SYNC_STAGES_DEF
) (
  input  logic i_CLK,
  input  logic i_RSTn,
  input  logic i_D,
  output logic o_Q
);

  localparam int DEPTH = irq_sync_depth(STAGES);

  logic [DEPTH-1:0] sync_q;
  logic [DEPTH-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[DEPTH-2:0], i_D};
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RSTn) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign o_Q = sync_q[DEPTH-1];

endmodule

// File: rtl/irq_gateway.sv
// Per-source interrupt gateway: synchronizes raw lines, latches edge or level
// requests until completion, and flags edges that arrive while already pending.
module irq_gateway
  import irq_gateway_pkg::*;
#(
  parameter int N_SRC       = IRQ_N_SRC_DEF,
  parameter int SYNC_STAGES = IRQ_SYNC_STAGES_DEF
) (
  input  logic                i_CLK,
  input  logic                i_RSTn,
  input  logic [N_SRC-1:0]    i_IRQ_RAW,
  input  logic [N_SRC-1:0]    i_EDGE_MODE,
  input  logic                i_COMPLETE,
  input  logic [IRQ_ID_W-1:0] i_COMPLETE_ID,
  input  logic [N_SRC-1:0]    i_OVR_CLR,
  output logic                o_MEI_0,
  output logic                o_MEI_1,
  output logic                o_MEI_2,
  output logic                o_MEI_3,
  output logic                o_MEI_4,
  output logic                o_MEI_5,
  output logic [N_SRC-1:0]    o_PENDING,
  output logic [N_SRC-1:0]    o_OVERRUN
);

  localparam int DEPTH  = irq_sync_depth(SYNC_STAGES);
  localparam int SETTLE = DEPTH + 1;
  localparam int CNT_W  = $clog2(SETTLE + 1);
  localparam int MEI_W  = (N_SRC > 6) ? N_SRC : 6;

  logic [N_SRC-1:0] irq_sync_w;
  logic [N_SRC-1:0] prev_q, prev_d;
  logic [N_SRC-1:0] mode_q, mode_d;
  logic [N_SRC-1:0] ovr_q, ovr_d;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] cmpl_hit;
  irq_state_e       state_q [N_SRC];
  irq_state_e       state_d [N_SRC];
  logic [CNT_W-1:0] settle_q, settle_d;
  logic             armed;
  logic [MEI_W-1:0] mei_vec;

  for (genvar g = 0; g < N_SRC; g++) begin : g_sync
    irq_sync #(
      .STAGES (DEPTH)
    ) u_sync (
      .i_CLK  (i_CLK),
      .i_RSTn (i_RSTn),
      .i_D    (i_IRQ_RAW[g]),
      .o_Q    (irq_sync_w[g])
    );
  end

  // Edges are only trusted once prev holds a value the chain actually sampled
  // after reset; otherwise a line held high through reset would look like a rise.
  assign armed = (settle_q == CNT_W'(SETTLE));

  always_comb begin
    settle_d = armed ? settle_q : settle_q + CNT_W'(1);
    prev_d   = irq_sync_w;
    mode_d   = i_EDGE_MODE;
    rise     = armed ? (irq_sync_w & ~prev_q) : '0;
    cmpl_hit = '0;
    ovr_d    = ovr_q & ~i_OVR_CLR;
    for (int i = 0; i < N_SRC; i++) begin
      cmpl_hit[i] = i_COMPLETE && (int'(i_COMPLETE_ID) == i);
      state_d[i]  = state_q[i];
      if (!i_EDGE_MODE[i]) begin
        state_d[i] = irq_sync_w[i] ? IRQ_PENDING : IRQ_IDLE;
      end else if (!mode_q[i]) begin
        // Entering edge mode drops whatever the level tracking left behind.
        state_d[i] = IRQ_IDLE;
      end else begin
        case (state_q[i])
          IRQ_IDLE: begin
            if (rise[i]) state_d[i] = IRQ_PENDING;
          end
          IRQ_PENDING: begin
            if (rise[i]) begin
              if (!cmpl_hit[i]) ovr_d[i] = 1'b1;
            end else if (cmpl_hit[i]) begin
              state_d[i] = IRQ_IDLE;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RSTn) begin
      settle_q <= '0;
      prev_q   <= '0;
      mode_q   <= '0;
      ovr_q    <= '0;
      for (int i = 0; i < N_SRC; i++) state_q[i] <= IRQ_IDLE;
    end else begin
      settle_q <= settle_d;
      prev_q   <= prev_d;
      mode_q   <= mode_d;
      ovr_q    <= ovr_d;
      for (int i = 0; i < N_SRC; i++) state_q[i] <= state_d[i];
    end
  end

  always_comb begin
    o_PENDING = '0;
    for (int i = 0; i < N_SRC; i++) o_PENDING[i] = (state_q[i] == IRQ_PENDING);
  end

  assign o_OVERRUN = ovr_q;
  assign mei_vec   = MEI_W'(o_PENDING);
  assign o_MEI_0   = mei_vec[0];
  assign o_MEI_1   = mei_vec[1];
  assign o_MEI_2   = mei_vec[2];
  assign o_MEI_3   = mei_vec[3];
  assign o_MEI_4   = mei_vec[4];
  assign o_MEI_5   = mei_vec[5];

endmodule

// File: tb/tb_irq_gateway.sv
// Directed and randomized bench for irq_gateway against an edge-indexed reference model.
module tb_irq_gateway;

  localparam int N = 6;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rstn;
  logic [5:0] raw;
  logic [5:0] mode;
  logic [5:0] ovr_clr;
  logic       cmpl;
  logic [2:0] cid;
  logic       mei0, mei1, mei2, mei3, mei4, mei5;
  logic [5:0] pend;
  logic [5:0] ovr;
  logic [5:0] mei;

  int checks   = 0;
  int failures = 0;

  // Model state: raw and mode as sampled at each clock edge since reset release.
  bit [5:0] hist[$];
  bit [5:0] mhist[$];
  bit [5:0] m_pend;
  bit [5:0] m_ovr;

  assign mei = {mei5, mei4, mei3, mei2, mei1, mei0};

  always #5 clk = ~clk;

  irq_gateway dut (
    .i_CLK         (clk),
    .i_RSTn        (rstn),
    .i_IRQ_RAW     (raw),
    .i_EDGE_MODE   (mode),
    .i_COMPLETE    (cmpl),
    .i_COMPLETE_ID (cid),
    .i_OVR_CLR     (ovr_clr),
    .o_MEI_0       (mei0),
    .o_MEI_1       (mei1),
    .o_MEI_2       (mei2),
    .o_MEI_3       (mei3),
    .o_MEI_4       (mei4),
    .o_MEI_5       (mei5),
    .o_PENDING     (pend),
    .o_OVERRUN     (ovr)
  );

  // Value seen by the gateway logic at edge e: raw as sampled S edges earlier,
  // zero while that sample predates reset release.
  function automatic bit [5:0] sync_at(int e);
    if (e - S >= 1) return hist[e-S-1];
    return '0;
  endfunction

  task automatic model_edge();
    int       e;
    bit [5:0] s, r, pm, np, set;
    bit       hit;
    if (!rstn) begin
      hist.delete();
      mhist.delete();
      m_pend = '0;
      m_ovr  = '0;
      return;
    end
    hist.push_back(raw);
    mhist.push_back(mode);
    e  = hist.size();
    pm = (e >= 2) ? mhist[e-2] : '0;
    s  = sync_at(e);
    r  = (e - 1 - S >= 1) ? (s & ~sync_at(e - 1)) : '0;
    np  = m_pend;
    set = '0;
    for (int i = 0; i < N; i++) begin
      hit = cmpl && (int'(cid) == i);
      if (!mode[i]) begin
        np[i] = s[i];
      end else if (!pm[i]) begin
        np[i] = 1'b0;
      end else if (r[i]) begin
        if (m_pend[i] && !hit) set[i] = 1'b1;
        np[i] = 1'b1;
      end else if (hit) begin
        np[i] = 1'b0;
      end
    end
    m_ovr  = (m_ovr & ~ovr_clr) | set;
    m_pend = np;
  endtask

  task automatic chk(string tag, logic [5:0] obs, logic [5:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("mei_vs_model", mei, m_pend);
    chk("pending_vs_model", pend, m_pend);
    chk("overrun_vs_model", ovr, m_ovr);
  endtask

  initial begin
    rstn = 1'b0; raw = '0; mode = 6'h3F; ovr_clr = '0; cmpl = 1'b0; cid = '0;
    step(); step();
    chk("reset_pending", pend, 6'h00);
    chk("reset_overrun", ovr, 6'h00);
    rstn = 1'b1;
    repeat (5) step();

    // src2 edge: latency, completion, no retrigger while held high
    raw[2] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("s2_rise_latency", 6'(mei[2]), 6'(k >= 3));
    end
    cmpl = 1'b1; cid = 3'd2;
    step();
    cmpl = 1'b0;
    chk("s2_complete", 6'(mei[2]), 6'h00);
    repeat (5) step();
    chk("s2_no_retrigger", 6'(mei[2]), 6'h00);
    raw[2] = 1'b0;
    repeat (4) step();

    // src0 edge: two pulses without completion set overrun
    raw[0] = 1'b1; step(); raw[0] = 1'b0; repeat (5) step();
    raw[0] = 1'b1; step(); raw[0] = 1'b0; repeat (5) step();
    chk("s0_pending", 6'(mei[0]), 6'h01);
    chk("s0_overrun_set", ovr, 6'b000001);
    ovr_clr = 6'b000001; step(); ovr_clr = '0;
    chk("s0_overrun_clr", ovr, 6'b000000);
    cmpl = 1'b1; cid = 3'd0; step(); cmpl = 1'b0;
    chk("s0_complete", 6'(mei[0]), 6'h00);

    // src5 level: follows the synchronized line, completion ignored
    mode[5] = 1'b0;
    step();
    for (int k = 1; k <= 13; k++) begin
      raw[5] = (k <= 8);
      cmpl   = (k == 5);
      cid    = 3'd5;
      step();
      chk("s5_level", 6'(mei[5]), 6'(k >= 3 && k <= 10));
    end
    cmpl = 1'b0;

    // src1 edge: rise coincident with completion keeps pending, no overrun
    raw[1] = 1'b1; step(); raw[1] = 1'b0; repeat (4) step();
    chk("s1_first_pending", 6'(mei[1]), 6'h01);
    raw[1] = 1'b1; step(); step();
    cmpl = 1'b1; cid = 3'd1; step(); cmpl = 1'b0;
    chk("s1_coincident_pending", 6'(mei[1]), 6'h01);
    chk("s1_coincident_no_ovr", 6'(ovr[1]), 6'h00);
    cmpl = 1'b1; cid = 3'd7; step(); cmpl = 1'b0;
    chk("s1_bad_id_ignored", 6'(mei[1]), 6'h01);
    raw[1] = 1'b0;
    cmpl = 1'b1; cid = 3'd1; step(); cmpl = 1'b0;
    chk("s1_complete", 6'(mei[1]), 6'h00);

    // all sources pending, then reset with lines held high
    mode = 6'h3F; step();
    raw = 6'h3F; repeat (5) step();
    chk("all_pending", pend, 6'h3F);
    rstn = 1'b0; step(); rstn = 1'b1;
    chk("reset_mid_pending", pend, 6'h00);
    chk("reset_mid_overrun", ovr, 6'h00);
    repeat (8) step();
    chk("held_high_no_event", pend, 6'h00);

    // src3 level -> edge switch
    raw = '0; repeat (4) step();
    mode[3] = 1'b0; raw[3] = 1'b1; repeat (4) step();
    chk("s3_level_high", 6'(mei[3]), 6'h01);
    mode[3] = 1'b1; step();
    chk("s3_switch_clears", 6'(mei[3]), 6'h00);
    repeat (4) step();
    chk("s3_no_spurious", 6'(mei[3]), 6'h00);
    raw[3] = 1'b0; repeat (3) step();
    raw[3] = 1'b1; repeat (3) step();
    chk("s3_new_rise", 6'(mei[3]), 6'h01);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      raw = raw ^ (6'($urandom) & 6'($urandom) & 6'($urandom));
      if ($urandom_range(0, 29) == 0) mode = 6'($urandom);
      cmpl    = ($urandom_range(0, 3) == 0);
      cid     = 3'($urandom_range(0, 7));
      ovr_clr = ($urandom_range(0, 5) == 0) ? 6'($urandom) : 6'h00;
      rstn    = ($urandom_range(0, 149) != 0);
      step();
    end
    rstn = 1'b1; cmpl = 1'b0; ovr_clr = '0;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_gateway.md
IRQ_GATEWAY -- requirements
Module: irq_gateway

Interface
REQ-001 SHALL have parameter N_SRC, default 6, number of external interrupt sources.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth (min 2).
REQ-003 SHALL have i_CLK  input  1  core clock, all logic on rising edge.
REQ-004 SHALL have i_RSTn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have i_IRQ_RAW  input  N_SRC  asynchronous peripheral interrupt lines, active-high.
REQ-006 SHALL have i_EDGE_MODE  input  N_SRC  per-source mode: 1 = rising-edge, 0 = level.
REQ-007 SHALL have i_COMPLETE  input  1  one-cycle pulse from core at end of handler (MRET).
REQ-008 SHALL have i_COMPLETE_ID  input  3  source index being completed.
REQ-009 SHALL have i_OVR_CLR  input  N_SRC  per-source clear of sticky overrun flag.
REQ-010 SHALL have o_MEI_0 .. o_MEI_5  output  1 each  pending request per source, to the CSR block's machine-external-interrupt inputs.
REQ-011 SHALL have o_PENDING  output  N_SRC  same bits as o_MEI_x, packed, for debug/readback.
REQ-012 SHALL have o_OVERRUN  output  N_SRC  sticky flag: edge arrived while already pending.

Function
REQ-013 SHALL pass each i_IRQ_RAW bit through a SYNC_STAGES flip-flop chain before any use; raw lines SHALL drive no other logic.
REQ-014 SHALL keep a per-source register prev holding the previous synchronized value; rise = sync & ~prev.
REQ-015 Per-source state SHALL be IDLE (pending=0) or PENDING (pending=1).
REQ-016 Edge mode: IDLE->PENDING on rise; PENDING->IDLE on i_COMPLETE with i_COMPLETE_ID == index; otherwise hold.
REQ-017 Edge mode, rise and matching complete in the same cycle: source SHALL remain PENDING, overrun unchanged.
REQ-018 Edge mode, rise while PENDING without matching complete: stay PENDING, set overrun bit.
REQ-019 Level mode: pending SHALL be registered copy of synchronized level each cycle; i_COMPLETE ignored; overrun never set.
REQ-020 Latency: raw rising at cycle 0 (stable before edge 1) SHALL make o_MEI_x high after edge SYNC_STAGES+1 (edge 3 at default); same latency both modes.
REQ-021 Complete SHALL clear pending at the next edge (1-cycle latency); o_MEI_x low in the following cycle.
REQ-022 i_COMPLETE_ID >= N_SRC SHALL be ignored; i_COMPLETE without any pending source is a no-op.
REQ-023 Multiple sources may be PENDING simultaneously; no prioritisation inside this block.
REQ-024 Mode change level->edge SHALL clear pending at next edge; prev keeps tracking so a held-high line produces no spurious rise.
REQ-025 Mode change edge->level SHALL make pending follow the synchronized level from next edge.
REQ-026 Overrun bit SHALL clear on i_OVR_CLR bit; set and clear in same cycle -> set wins.
REQ-027 o_PENDING SHALL equal {o_MEI_5..o_MEI_0} at all times.

Reset
REQ-028 On i_RSTn=0 at a clock edge: sync chains, prev, pending and overrun SHALL all be 0; all outputs 0 the cycle after.
REQ-029 Reset mid-operation SHALL discard all pending and overrun state; line held high through reset release SHALL not generate an edge-mode event (prev loaded after sync settles, i.e. rise requires a 0 seen after reset).

Structure
REQ-030 N_SRC default, SYNC_STAGES default, state encoding (IDLE=0, PENDING=1) SHALL live in shared include irq_defs.vh.
REQ-031 Synchronizer SHALL be sub-module irq_sync (parameter STAGES, 1-bit in/out), instantiated N_SRC times via generate.
REQ-032 Gateway logic SHALL be fully synchronous, no latches, no combinational path from i_IRQ_RAW to outputs.

Verification
REQ-033 Edge mode src2: raw 0->1 at cycle 0, held -> o_MEI_2=1 from edge 3, stays 1; complete id=2 at cycle 10 -> o_MEI_2=0 at cycle 11, no re-trigger while raw stays high.
REQ-034 Edge mode src0: two pulses 6 cycles apart, no complete -> o_MEI_0=1, o_OVERRUN=6'b000001; i_OVR_CLR[0] pulse -> 6'b000000.
REQ-035 Level mode src5: raw high cycles 0-7 -> o_MEI_5 high edges 3-10, low after; i_COMPLETE id=5 during high has no effect.
REQ-036 Edge mode src1: second rise coincident with complete id=1 -> o_MEI_1 stays 1, o_OVERRUN[1]=0; complete id=7 -> ignored.
REQ-037 All 6 sources edge-pending, i_RSTn low one cycle -> o_PENDING=0, o_OVERRUN=0; raw held high through reset -> no new pending.
REQ-038 Src3 raw high in level mode (o_MEI_3=1), switch to edge mode -> o_MEI_3=0 next cycle, stays 0 until raw falls and rises again.
